load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage directly downstream of the ALU.
- Consumes the ALU-computed address, the store data from register port B, func3 and the MemRead/MemWrite controls.
- Drives a word-wide external data bus with a req/ack handshake, then returns an aligned, sign- or zero-extended load result for the register write-back mux.
- Asserts stall to freeze the PC while a bus access is in flight.

Parameters:
TIMEOUT, 255, max REQ cycles to wait for mem_ack before aborting (1..65535)

Ports:
clk  input  1  core clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
MemRead  input  1  load request from control unit (level, held while stall=1)
MemWrite  input  1  store request from control unit (level, held while stall=1)
func3  input  3  instruction[14:12], access size/sign
addrs  input  32  byte address from ALU result
wr_data  input  32  store data (register port B)
rd_data  output  32  extended load result, valid in DONE
stall  output  1  core must hold PC/inputs while high
fault  output  1  misaligned or illegal func3 for presented request
err  output  1  bus timeout, valid in DONE
mem_req  output  1  bus request
mem_we  output  1  1=write, 0=read
mem_addr  output  32  word address {addrs[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables
mem_rdata  input  32  bus read data, valid with mem_ack
mem_ack  input  1  one-cycle bus completion

Behaviour:
- Reset values: state=IDLE; rd_data=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, timeout counter=0. stall and fault are combinational and evaluate to 0 in IDLE with no request.
- Request present = MemRead|MemWrite. If both are high, the access is a store; MemRead is ignored.
- Legal func3, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal func3, stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addrs[0]=1; word with addrs[1:0]!=0.
- fault = IDLE & request & (illegal func3 | misaligned).
  - A faulting request issues no bus access; stall=0 and rd_data is forced to 0 that cycle.
  - Core handles the fault.
- State machine: IDLE -> REQ -> DONE -> IDLE.
  - IDLE: on a legal request, stall=1 combinationally. At the clock edge: latch mem_addr, mem_we, mem_be, mem_wdata, func3 and addrs[1:0]; set mem_req=1; clear the counter; go to REQ.
  - REQ: mem_req=1, stall=1, counter increments each cycle.
    - mem_ack=1: capture the extended load data into rd_data (stores leave rd_data=0), err=0, mem_req=0, go to DONE.
    - Counter reaches TIMEOUT-1 without ack: mem_req=0, rd_data=0, err=1, go to DONE.
  - DONE: stall=0 for exactly one cycle; the core commits at the end of this cycle. No new request is accepted in DONE. Unconditional return to IDLE; err and rd_data hold until the next access completes.
- Latency: with ack in the first REQ cycle, the request is seen in cycle 0, ack in cycle 1, commit in cycle 2. Total stall = 2 cycles + ack wait.
- Byte enables: SB/LB/LBU = 4'b0001<<addrs[1:0]; SH/LH/LHU = 4'b0011<<{addrs[1],1'b0}; SW/LW = 4'b1111.
- mem_wdata: SB = {4{wr_data[7:0]}}; SH = {2{wr_data[15:0]}}; SW = wr_data.
- Load extraction:
  - Select byte lane addrs[1:0] or halfword lane addrs[1].
  - LB/LH sign-extend bit 7/15 to 32 bits; LBU/LHU zero-extend.
  - LW passes through.
- Boundary cases:
  - mem_ack in IDLE or DONE is ignored.
  - mem_ack in the same cycle as the timeout compare: ack wins, err=0.
  - rst asserted in any state: next edge returns to IDLE with reset values; mem_req drops that edge; a late ack is ignored.
  - Address wrap: mem_addr carries bits [31:2] unchanged; no carry logic.

Test Plan:
- LW addrs=0x100, ack after 3 REQ cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111; stall high 4 cycles; DONE rd_data=0xDEADBEEF, err=0.
- LB addrs=0x103, mem_rdata=0x80112233 -> mem_be=1000, rd_data=0xFFFFFF80. LBU same -> 0x00000080. LH addrs=0x102 -> 0xFFFF8011.
- SH addrs=0x0A, wr_data=0x1234ABCD, ack after 1 cycle -> mem_we=1, mem_addr=0x08, mem_be=1100, mem_wdata=0xABCDABCD; rd_data=0.
- LW addrs=0x102 -> fault=1, stall=0, mem_req stays 0. SW with func3=011 -> fault=1. MemRead with func3=110 -> fault=1.
- TIMEOUT=4, LW with no ack -> mem_req high exactly 4 cycles, then DONE with err=1, rd_data=0. Ack arriving 2 cycles later is ignored, state stays IDLE.
- rst pulsed during the 2nd REQ cycle of a load -> mem_req=0 and state IDLE after that edge. Subsequent ack is ignored. Next LW completes normally with err=0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage behind the ALU.
// Issues one word-wide req/ack bus access and returns extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] addrs,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        fault,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rd_q;

    logic        request;
    logic        is_store;
    logic        f3_ok;
    logic        misalign;
    logic        accept;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;

    // Request decode: legality, alignment, lane enables and store data.
    always_comb begin
        request  = MemRead | MemWrite;
        is_store = MemWrite;
        case (func3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~is_store;
            default:                f3_ok = 1'b0;
        endcase
        misalign = ((func3[1:0] == 2'b01) & addrs[0])
                 | ((func3[1:0] == 2'b10) & (addrs[1:0] != 2'b00));
        fault  = (state == S_IDLE) & request & (~f3_ok | misalign);
        accept = (state == S_IDLE) & request & ~fault;
        stall  = accept | (state == S_REQ);
        case (func3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << addrs[1:0];
                wdata_n = {4{wr_data[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << {addrs[1], 1'b0};
                wdata_n = {2{wr_data[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = wr_data;
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returning read data.
    always_comb begin
        byte_v = mem_rdata[{off_q, 3'b000} +: 8];
        half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{16{half_v[15]}}, half_v};
            3'b100:  load_ext = {24'd0, byte_v};
            3'b101:  load_ext = {16'd0, half_v};
            default: load_ext = mem_rdata;
        endcase
    end

    // A faulting request must not leak stale load data to write-back.
    assign rd_data = fault ? 32'd0 : rd_q;

    // Access sequencer: IDLE -> REQ -> DONE -> IDLE with ack timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 16'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            rd_q      <= 32'd0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mem_addr  <= {addrs[31:2], 2'b00};
                        mem_we    <= is_store;
                        mem_be    <= be_n;
                        mem_wdata <= wdata_n;
                        f3_q      <= func3;
                        off_q     <= addrs[1:0];
                        mem_req   <= 1'b1;
                        cnt       <= 16'd0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        rd_q    <= mem_we ? 32'd0 : load_ext;
                        err     <= 1'b0;
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rd_q    <= 32'd0;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
